// File: rtl/usb_line_rx_if.sv
// usb_line_rx_if: bundles the byte-stream, line-buffer and echo signals of usb_line_rx.
//   uart_out_*   : byte stream from the USB serial pipeline (valid/ready).
//   line_*       : held-line status, registered buffer read port and release strobe.
//   echo_*       : echoed byte stream toward the USB serial input pipeline (valid/ready).
// Modports: slave = usb_line_rx side, master = producer/consumer side.
interface usb_line_rx_if;
  logic [7:0] uart_out_data;
  logic       uart_out_valid;
  logic       uart_out_ready;
  logic       line_valid;
  logic [4:0] line_len;
  logic       line_overflow;
  logic [3:0] line_rd_addr;
  logic [7:0] line_rd_data;
  logic       line_ack;
  logic [7:0] echo_data;
  logic       echo_valid;
  logic       echo_ready;

  modport slave (
    input  uart_out_data, uart_out_valid, line_rd_addr, line_ack, echo_ready,
    output uart_out_ready, line_valid, line_len, line_overflow, line_rd_data,
    output echo_data, echo_valid
  );

  modport master (
    output uart_out_data, uart_out_valid, line_rd_addr, line_ack, echo_ready,
    input  uart_out_ready, line_valid, line_len, line_overflow, line_rd_data,
    input  echo_data, echo_valid
  );
endinterface

// File: rtl/usb_line_rx.sv
// usb_line_rx: collects bytes from the USB serial pipeline into a line buffer of MAX_LEN
// bytes (legal 2..16). CR/LF terminate a line and are never stored; empty lines are dropped.
// A completed line is held (line_valid) until line_ack, during which no bytes are accepted.
// Bytes past MAX_LEN are dropped and flagged by line_overflow.
// Ports:
//   clk_48mhz : sole clock, rising edge.
//   reset     : asynchronous, active-high.
//   bus       : usb_line_rx_if.slave (byte stream in, line status/read port, echo stream out).
// Optional feature: define USB_LINE_RX_ECHO_EN to echo every accepted byte (terminators
// included) through a single-entry register on echo_data/echo_valid. Without it the echo
// outputs are tied to zero and echo_ready is ignored.
module usb_line_rx #(
  parameter int unsigned MAX_LEN = 16
) (
  input  logic         clk_48mhz,
  input  logic         reset,
  usb_line_rx_if.slave bus
);

  localparam logic [4:0] MaxLen = 5'(MAX_LEN);
  localparam logic [7:0] ChrCr  = 8'h0D;
  localparam logic [7:0] ChrLf  = 8'h0A;

  typedef enum logic [0:0] {StRecv, StHold} state_e;

  state_e     state_q, state_d;
  logic [4:0] count_q, count_d;
  logic [4:0] line_len_q, line_len_d;
  logic       overflow_q, overflow_d;
  logic       ready_en_q, ready_en_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic [7:0] line_buf_q [MAX_LEN];

  logic buf_we;
  logic accept;
  logic is_term;
  logic echo_block;
  logic ready;

  // ---------------------------------------------------------------------------
  // Optional echo register
  // ---------------------------------------------------------------------------
`ifdef USB_LINE_RX_ECHO_EN
  logic       echo_valid_q, echo_valid_d;
  logic [7:0] echo_data_q, echo_data_d;

  // A full echo slot that is not draining this cycle blocks new input.
  assign echo_block = echo_valid_q && !bus.echo_ready;

  always_comb begin
    echo_valid_d = echo_valid_q;
    echo_data_d  = echo_data_q;
    if (accept) begin
      echo_valid_d = 1'b1;
      echo_data_d  = bus.uart_out_data;
    end else if (bus.echo_ready) begin
      echo_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      echo_valid_q <= 1'b0;
      echo_data_q  <= 8'h00;
    end else begin
      echo_valid_q <= echo_valid_d;
      echo_data_q  <= echo_data_d;
    end
  end

  assign bus.echo_valid = echo_valid_q;
  assign bus.echo_data  = echo_data_q;
`else
  logic unused_echo_ready;
  assign unused_echo_ready = bus.echo_ready;
  assign echo_block        = 1'b0;
  assign bus.echo_valid    = 1'b0;
  assign bus.echo_data     = 8'h00;
`endif

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // ready_en_q keeps ready low during reset and until the first edge after it.
  assign ready   = ready_en_q && (state_q == StRecv) && !echo_block;
  assign accept  = bus.uart_out_valid && ready;
  assign is_term = (bus.uart_out_data == ChrCr) || (bus.uart_out_data == ChrLf);

  assign ready_en_d = 1'b1;

  // ---------------------------------------------------------------------------
  // Line FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    line_len_d = line_len_q;
    overflow_d = overflow_q;
    buf_we     = 1'b0;
    case (state_q)
      StRecv: begin
        if (accept) begin
          if (is_term) begin
            // A terminator on an empty line (CRLF tail, blank line) is swallowed.
            if (count_q != 5'd0) begin
              state_d    = StHold;
              line_len_d = count_q;
            end
          end else if (count_q < MaxLen) begin
            buf_we  = 1'b1;
            count_d = count_q + 5'd1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      StHold: begin
        if (bus.line_ack) begin
          state_d    = StRecv;
          count_d    = 5'd0;
          line_len_d = 5'd0;
          overflow_d = 1'b0;
        end
      end
      default: begin
        state_d = StRecv;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state_q    <= StRecv;
      count_q    <= 5'd0;
      line_len_q <= 5'd0;
      overflow_q <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      line_len_q <= line_len_d;
      overflow_q <= overflow_d;
      ready_en_q <= ready_en_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffer: not reset, so contents survive HOLD and reset; only new bytes overwrite.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_48mhz) begin
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (buf_we && (count_q == 5'(i))) begin
        line_buf_q[i] <= bus.uart_out_data;
      end
    end
  end

  // Registered read port; addresses beyond the buffer depth read as zero.
  always_comb begin
    rd_data_d = 8'h00;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (bus.line_rd_addr == 4'(i)) begin
        rd_data_d = line_buf_q[i];
      end
    end
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.uart_out_ready = ready;
  assign bus.line_valid     = (state_q == StHold);
  assign bus.line_len       = line_len_q;
  assign bus.line_overflow  = overflow_q;
  assign bus.line_rd_data   = rd_data_q;

endmodule

// File: tb/tb_usb_line_rx.sv
// Bench for usb_line_rx: directed line scenarios plus a randomized byte stream, all checked
// every cycle against a line-level reference model (byte queue + persistent buffer image).
module tb_usb_line_rx;

  localparam int unsigned MaxLen = 16;

  logic clk_48mhz = 1'b0;
  logic reset;

  usb_line_rx_if bus ();

  usb_line_rx #(.MAX_LEN(MaxLen)) dut (
    .clk_48mhz(clk_48mhz),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the line in progress is a byte queue; a separate image of the buffer
  // keeps whatever bytes were ever stored, since storage is never cleared.
  // ---------------------------------------------------------------------------
  logic [7:0] m_line [$];
  logic [7:0] m_mem [MaxLen];
  bit         m_known [MaxLen];
  logic       m_started, m_hold, m_ovf, m_ev, m_rd_known;
  int         m_len;
  logic [7:0] m_ed, m_rd;
  logic       m_ready, m_acc, m_term;

`ifdef USB_LINE_RX_ECHO_EN
  assign m_ready = m_started && !m_hold && !(m_ev && !bus.echo_ready);
`else
  assign m_ready = m_started && !m_hold;
`endif
  assign m_acc  = bus.uart_out_valid && m_ready;
  assign m_term = (bus.uart_out_data == 8'h0D) || (bus.uart_out_data == 8'h0A);

  always @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      m_started  <= 1'b0;
      m_hold     <= 1'b0;
      m_ovf      <= 1'b0;
      m_len      <= 0;
      m_ev       <= 1'b0;
      m_ed       <= 8'h00;
      m_rd       <= 8'h00;
      m_rd_known <= 1'b1;
      m_line.delete();
    end else begin
      m_started <= 1'b1;
      if (m_known[bus.line_rd_addr]) begin
        m_rd       <= m_mem[bus.line_rd_addr];
        m_rd_known <= 1'b1;
      end else begin
        m_rd_known <= 1'b0;
      end
      if (m_acc) begin
        if (m_term) begin
          if (m_line.size() > 0) begin
            m_hold <= 1'b1;
            m_len  <= m_line.size();
          end
        end else if (m_line.size() < MaxLen) begin
          m_mem[m_line.size()]   <= bus.uart_out_data;
          m_known[m_line.size()] <= 1'b1;
          m_line.push_back(bus.uart_out_data);
        end else begin
          m_ovf <= 1'b1;
        end
      end else if (m_hold && bus.line_ack) begin
        m_hold <= 1'b0;
        m_len  <= 0;
        m_ovf  <= 1'b0;
        m_line.delete();
      end
`ifdef USB_LINE_RX_ECHO_EN
      if (m_acc) begin
        m_ev <= 1'b1;
        m_ed <= bus.uart_out_data;
      end else if (bus.echo_ready) begin
        m_ev <= 1'b0;
      end
`endif
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk_48mhz) begin
    chk("uart_out_ready", 32'(bus.uart_out_ready), 32'(m_ready));
    chk("line_valid", 32'(bus.line_valid), 32'(m_hold));
    chk("line_len", 32'(bus.line_len), 32'(m_len));
    chk("line_overflow", 32'(bus.line_overflow), 32'(m_ovf));
    chk("echo_valid", 32'(bus.echo_valid), 32'(m_ev));
    chk("echo_data", 32'(bus.echo_data), 32'(m_ed));
    if (m_rd_known) chk("line_rd_data", 32'(bus.line_rd_data), 32'(m_rd));
  end

  // ---------------------------------------------------------------------------
  // Byte driver: presents the queue head, pops it once the handshake completes.
  // ---------------------------------------------------------------------------
  logic [7:0] q [$];
  logic       drv_acc = 1'b0;
  int         drv_gap = 0;

  initial begin
    bus.uart_out_valid = 1'b0;
    bus.uart_out_data  = 8'h00;
    forever begin
      @(posedge clk_48mhz);
      if (drv_acc && q.size() > 0) void'(q.pop_front());
      #1;
      bus.uart_out_valid = (q.size() > 0) && ($urandom_range(99) >= drv_gap);
      bus.uart_out_data  = (q.size() > 0) ? q[0] : 8'h00;
      @(negedge clk_48mhz);
      drv_acc = bus.uart_out_valid && bus.uart_out_ready;
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers (main process lives at negedge + 1)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk_48mhz);
    #1;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endtask

  task automatic wait_line(input string name);
    int n = 0;
    while (bus.line_valid !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk(name, 32'(bus.line_valid), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (q.size() > 0 && n < 300) begin
      step();
      n++;
    end
    chk(name, 32'(q.size()), 32'd0);
  endtask

  task automatic read_chk(input logic [3:0] addr, input logic [7:0] exp, input string name);
    bus.line_rd_addr = addr;
    step();
    chk(name, 32'(bus.line_rd_data), 32'(exp));
  endtask

  task automatic read_str(input string s, input string name);
    for (int i = 0; i < s.len(); i++) read_chk(4'(i), s[i], name);
  endtask

  task automatic ack();
    bus.line_ack = 1'b1;
    step();
    bus.line_ack = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset            = 1'b1;
    bus.line_ack     = 1'b0;
    bus.line_rd_addr = 4'd0;
    bus.echo_ready   = 1'b1;
    repeat (2) step();

    // Reset state
    chk("rst_ready", 32'(bus.uart_out_ready), 32'd0);
    chk("rst_line_valid", 32'(bus.line_valid), 32'd0);
    chk("rst_line_len", 32'(bus.line_len), 32'd0);
    chk("rst_overflow", 32'(bus.line_overflow), 32'd0);
    chk("rst_rd_data", 32'(bus.line_rd_data), 32'd0);
    chk("rst_echo_valid", 32'(bus.echo_valid), 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_before_edge", 32'(bus.uart_out_ready), 32'd0);
    step();
    chk("ready_after_edge", 32'(bus.uart_out_ready), 32'd1);

    // Hello World, LF stays pending while the line is held
    push_str("Hello World!");
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    wait_line("hello_line_timeout");
    chk("hello_len", 32'(bus.line_len), 32'd12);
    chk("hello_model_len", 32'(m_len), 32'd12);
    chk("hello_overflow", 32'(bus.line_overflow), 32'd0);
    repeat (5) step();
    chk("hello_lf_pending", 32'(q.size()), 32'd1);
    read_str("Hello World!", "hello_data");
    ack();
    wait_drain("hello_lf_drain");
    repeat (2) step();
    chk("lf_makes_no_line", 32'(bus.line_valid), 32'd0);

    // Held line blocks 'X' for 10 cycles; after ack 'X' starts the next line
    push_str("ab");
    q.push_back(8'h0D);
    wait_line("ab_line_timeout");
    push_str("X");
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_ready_low", 32'(bus.uart_out_ready), 32'd0);
    end
    chk("hold_x_offered", 32'(bus.uart_out_valid), 32'd1);
    ack();
    q.push_back(8'h0D);
    wait_line("x_line_timeout");
    chk("x_len", 32'(bus.line_len), 32'd1);
    read_chk(4'd0, "X", "x_addr0");
    read_chk(4'd1, "b", "buffer_preserved");
    ack();

    // Overflow: 20 bytes then CR
    push_str("ABCDEFGHIJKLMNOPQRST");
    q.push_back(8'h0D);
    wait_line("ovf_line_timeout");
    chk("ovf_len", 32'(bus.line_len), 32'd16);
    chk("ovf_flag", 32'(bus.line_overflow), 32'd1);
    read_chk(4'd15, "P", "ovf_addr15");
    read_chk(4'd0, "A", "ovf_addr0");
    ack();
    chk("ovf_cleared", 32'(bus.line_overflow), 32'd0);

    // Blank lines produce nothing; "ok" is the only line
    q.push_back(8'h0D); q.push_back(8'h0A); q.push_back(8'h0D); q.push_back(8'h0A);
    push_str("ok");
    q.push_back(8'h0A);
    wait_line("ok_line_timeout");
    chk("ok_len", 32'(bus.line_len), 32'd2);
    read_str("ok", "ok_data");
    ack();
    repeat (10) step();
    chk("ok_single_line", 32'(bus.line_valid), 32'd0);

    // Reset mid-line discards the partial line
    push_str("abc");
    wait_drain("abc_drain");
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    push_str("de");
    q.push_back(8'h0D);
    wait_line("de_line_timeout");
    chk("de_len", 32'(bus.line_len), 32'd2);
    chk("de_overflow", 32'(bus.line_overflow), 32'd0);
    read_str("de", "de_data");
    ack();

`ifdef USB_LINE_RX_ECHO_EN
    // Echo back-pressure
    bus.echo_ready = 1'b0;
    push_str("Z");
    wait_drain("z_drain");
    for (int i = 0; i < 5; i++) begin
      chk("echo_z_valid", 32'(bus.echo_valid), 32'd1);
      chk("echo_z_data", 32'(bus.echo_data), 32'h5A);
      chk("echo_z_ready_low", 32'(bus.uart_out_ready), 32'd0);
      step();
    end
    bus.echo_ready = 1'b1;
    step();
    chk("echo_z_drained", 32'(bus.echo_valid), 32'd0);
    chk("echo_z_ready_high", 32'(bus.uart_out_ready), 32'd1);
    q.push_back(8'h0D);
    wait_line("z_line_timeout");
    ack();
`else
    chk("echo_off_valid", 32'(bus.echo_valid), 32'd0);
    chk("echo_off_data", 32'(bus.echo_data), 32'd0);
`endif

    // Randomized stream
    drv_gap = 25;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int tp;
      int r;
      tp = ((cyc / 500) % 2 == 0) ? 20 : 3;
      if (q.size() < 3) begin
        r = $urandom_range(99);
        if (r < tp / 2) q.push_back(8'h0D);
        else if (r < tp) q.push_back(8'h0A);
        else q.push_back(8'(8'h41 + $urandom_range(25)));
      end
      bus.line_rd_addr = 4'($urandom_range(15));
      bus.echo_ready   = ($urandom_range(3) != 0);
      bus.line_ack     = bus.line_valid ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
      if ($urandom_range(799) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      step();
    end
    bus.line_ack   = 1'b0;
    bus.echo_ready = 1'b1;
    drv_gap        = 0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_line_rx.md
USB_LINE_RX -- requirements
Module: usb_line_rx

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, giving the line buffer depth in bytes (legal values 2..16).
REQ-002 SHALL have port clk_48mhz  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port uart_out_data  input  8  received byte from the USB serial pipeline.
REQ-005 SHALL have port uart_out_valid  input  1  uart_out_data is valid.
REQ-006 SHALL have port uart_out_ready  output  1  block accepts the byte this cycle.
REQ-007 SHALL have port line_valid  output  1  complete line held in the buffer.
REQ-008 SHALL have port line_len  output  5  byte count of the held line, terminator excluded.
REQ-009 SHALL have port line_overflow  output  1  the held line lost bytes beyond MAX_LEN.
REQ-010 SHALL have port line_rd_addr  input  4  buffer read address.
REQ-011 SHALL have port line_rd_data  output  8  buffer byte at line_rd_addr, registered.
REQ-012 SHALL have port line_ack  input  1  consumer releases the held line.
REQ-013 SHALL have port echo_data  output  8  echoed byte toward the USB serial input pipeline.
REQ-014 SHALL have port echo_valid  output  1  echo_data is valid.
REQ-015 SHALL have port echo_ready  input  1  echo sink accepts this cycle.

Function
REQ-016 SHALL implement a two-state machine, RECV and HOLD.
REQ-017 SHALL accept a byte when uart_out_valid and uart_out_ready are both high in the same cycle.
REQ-018 In RECV, SHALL drive uart_out_ready high, except when an echo is pending (REQ-032); in HOLD, SHALL drive uart_out_ready low.
REQ-019 SHALL treat 0x0D (CR) and 0x0A (LF) as terminators and never store them.
REQ-020 On an accepted terminator with count 0: SHALL drop the byte and stay in RECV, so CRLF and blank lines produce no line.
REQ-021 On an accepted terminator with count > 0: SHALL enter HOLD next cycle with line_valid=1 and line_len=count.
REQ-022 On an accepted non-terminator with count < MAX_LEN: SHALL write the byte to buf[count] and increment count.
REQ-023 On an accepted non-terminator with count == MAX_LEN: SHALL drop the byte and set line_overflow, which stays set until the line is released.
REQ-024 line_len SHALL saturate at MAX_LEN; count SHALL never wrap.
REQ-025 line_rd_data SHALL equal buf[line_rd_addr] sampled on the previous edge (1-cycle latency), valid in any state; addresses >= line_len return stale contents.
REQ-026 In HOLD, line_ack high SHALL clear line_valid, line_len, line_overflow and count and return to RECV on the same edge; uart_out_ready rises the following cycle.
REQ-027 line_ack SHALL be ignored in RECV.
REQ-028 Buffer contents SHALL be preserved across HOLD and overwritten only by new bytes.

Reset
REQ-029 While reset is high: state=RECV, count=0, line_valid=0, line_len=0, line_overflow=0, echo_valid=0, echo_data=0, line_rd_data=0, and uart_out_ready=0.
REQ-030 uart_out_ready SHALL first rise on the first clock edge after reset deasserts.
REQ-031 Reset asserted mid-line SHALL discard the partial line; buffer RAM contents are not cleared.

Configuration
REQ-032 With macro USB_LINE_RX_ECHO_EN defined: every accepted byte, terminators included, SHALL load a single-entry echo register; echo_valid is held with stable echo_data until echo_ready; uart_out_ready SHALL be low while echo_valid is high and echo_ready is low.
REQ-033 Without USB_LINE_RX_ECHO_EN: echo_valid=0, echo_data=0, echo_ready ignored, and ports retained so instantiations are unchanged.

Verification
REQ-034 Stream "Hello World!\r\n", one byte per cycle -> line_valid=1, line_len=12, line_overflow=0; reads of addresses 0..11 return "Hello World!"; the LF is never consumed before line_ack.
REQ-035 In HOLD, keep uart_out_valid high with 'X' for 10 cycles -> uart_out_ready=0 throughout; pulse line_ack -> next line starts with 'X' at addr 0.
REQ-036 20 bytes "A".."T" then CR -> line_len=16, line_overflow=1, addr 15 = 'P'; after line_ack, line_overflow=0.
REQ-037 "\r\n\r\n" then "ok\n" -> exactly one line, line_len=2, contents "ok".
REQ-038 "abc", reset pulse, then "de\r" -> line_len=2, contents "de", line_overflow=0.
REQ-039 Echo build with echo_ready low for 5 cycles after 'Z' is accepted -> echo_valid=1, echo_data=0x5A stable, uart_out_ready=0; echo_ready=1 -> echo_valid drops and uart_out_ready=1 next cycle.
